// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: frame-synchronous capture, hex decode, dp/blank/blink,
// leading-zero suppression and dead time between digit slots.
module seg_scan_driver #(
   parameter int unsigned NUM_DIGITS     = 6,
   parameter int unsigned SCAN_CYCLES    = 1000,
   parameter int unsigned BLANK_CYCLES   = 50,
   parameter int unsigned BLINK_CYCLES   = 25_000_000,
   parameter int unsigned SEL_ACTIVE_LOW = 1,
   parameter int unsigned SEG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]     dot_en,
   input  logic [NUM_DIGITS-1:0]     blank_en,
   input  logic [NUM_DIGITS-1:0]     blink_en,
   input  logic                      lz_suppress,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     sel,
   output logic                      frame_start
);

   localparam int unsigned CW = $clog2(SCAN_CYCLES);
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam int unsigned DW = 4 * NUM_DIGITS;

   // XOR masks that also serve as the all-inactive output values
   localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [BW-1:0]         blk_cnt_q, blk_cnt_d;
   logic                  blk_ph_q, blk_ph_d;
   logic [DW-1:0]         data_q, data_d;
   logic [NUM_DIGITS-1:0] dot_q, dot_d, blank_q, blank_d, blink_q, blink_d;
   logic                  lz_q, lz_d, ph_q, ph_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;

   logic                  capture_c, cnt_wrap_c, blk_wrap_c;
   logic [NUM_DIGITS-1:0] supp_c;
   logic [3:0]            nib_c;
   logic                  dp_c, bl_c, bk_c, sp_c, zero_run_c;
   logic [7:0]            raw_c;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   assign capture_c   = (idx_q == '0) && (cnt_q == '0);
   assign frame_start = rstn && capture_c;
   assign seg         = seg_q;
   assign sel         = sel_q;

   // Next-state: slot/digit/blink counters and frame shadow capture
   always_comb begin
      cnt_wrap_c = (cnt_q == CW'(SCAN_CYCLES - 1));
      blk_wrap_c = (blk_cnt_q == BW'(BLINK_CYCLES - 1));
      cnt_d      = cnt_wrap_c ? '0 : cnt_q + CW'(1);
      idx_d      = idx_q;
      if (cnt_wrap_c) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      blk_cnt_d  = blk_wrap_c ? '0 : blk_cnt_q + BW'(1);
      blk_ph_d   = blk_wrap_c ? ~blk_ph_q : blk_ph_q;
      data_d     = capture_c ? data_in     : data_q;
      dot_d      = capture_c ? dot_en      : dot_q;
      blank_d    = capture_c ? blank_en    : blank_q;
      blink_d    = capture_c ? blink_en    : blink_q;
      lz_d       = capture_c ? lz_suppress : lz_q;
      ph_d       = capture_c ? blk_ph_q    : ph_q;
   end

   // Output decode for the current (idx, cnt) slot from shadow values
   always_comb begin
      supp_c     = '0;
      zero_run_c = 1'b1;
      nib_c      = '0;
      dp_c       = 1'b0;
      bl_c       = 1'b0;
      bk_c       = 1'b0;
      sp_c       = 1'b0;
      raw_c      = '0;
      sel_d      = SEL_OFF;
      seg_d      = SEG_OFF;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         zero_run_c = zero_run_c && (data_q[4*i +: 4] == 4'h0);
         supp_c[i]  = zero_run_c && lz_q && (i != 0);
      end
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IW'(i)) begin
            nib_c = data_q[4*i +: 4];
            dp_c  = dot_q[i];
            bl_c  = blank_q[i];
            bk_c  = blink_q[i];
            sp_c  = supp_c[i];
         end
      end
      if (bl_c || (bk_c && ph_q)) raw_c = 8'h00;
      else if (sp_c)              raw_c = {dp_c, 7'h00};
      else                        raw_c = {dp_c, hex7(nib_c)};
      if (cnt_q >= CW'(BLANK_CYCLES)) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++) sel_d[i] = (idx_q == IW'(i)) ^ SEL_OFF[i];
         seg_d = raw_c ^ SEG_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         blk_cnt_q <= '0;
         blk_ph_q  <= 1'b0;
         data_q    <= '0;
         dot_q     <= '0;
         blank_q   <= '0;
         blink_q   <= '0;
         lz_q      <= 1'b0;
         ph_q      <= 1'b0;
         seg_q     <= SEG_OFF;
         sel_q     <= SEL_OFF;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         blk_cnt_q <= blk_cnt_d;
         blk_ph_q  <= blk_ph_d;
         data_q    <= data_d;
         dot_q     <= dot_d;
         blank_q   <= blank_d;
         blink_q   <= blink_d;
         lz_q      <= lz_d;
         ph_q      <= ph_d;
         seg_q     <= seg_d;
         sel_q     <= sel_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver against a cycle-count based reference model.
module tb_seg_scan_driver;

   localparam int N  = 4;
   localparam int S  = 8;
   localparam int BL = 2;
   localparam int B  = 64;
   localparam int F  = N * S;

   logic         clk = 1'b0;
   logic         rstn;
   logic [15:0]  data_in;
   logic [3:0]   dot_en, blank_en, blink_en;
   logic         lz_suppress;
   logic [7:0]   seg;
   logic [3:0]   sel;
   logic         frame_start;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: k = cycles since the last reset edge; shadow copies of the frame inputs
   int          k = 0;
   logic [15:0] m_data;
   logic [3:0]  m_dot, m_blank, m_blink;
   logic        m_lz, m_ph;
   logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg_scan_driver #(
      .NUM_DIGITS(N), .SCAN_CYCLES(S), .BLANK_CYCLES(BL), .BLINK_CYCLES(B),
      .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rstn(rstn), .data_in(data_in), .dot_en(dot_en), .blank_en(blank_en),
      .blink_en(blink_en), .lz_suppress(lz_suppress), .seg(seg), .sel(sel),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   // Expected registered outputs produced from the model's cycle kp
   task automatic expect_out(input int kp, output logic [7:0] es, output logic [3:0] esel);
      int c, d;
      logic [3:0] nib;
      logic [7:0] raw;
      logic lzs;
      c = kp % S;
      d = (kp / S) % N;
      if (c < BL) begin
         es = 8'hFF;
         esel = 4'hF;
      end else begin
         nib = 4'(m_data >> (4 * d));
         lzs = m_lz && (d > 0) && ((m_data >> (4 * d)) == 16'h0);
         if (m_blank[d] || (m_blink[d] && m_ph)) raw = 8'h00;
         else if (lzs)                          raw = {m_dot[d], 7'h00};
         else                                   raw = {m_dot[d], hex_tbl[nib]};
         es   = ~raw;
         esel = ~(4'b0001 << d);
      end
   endtask

   task automatic tick();
      logic [7:0] es;
      logic [3:0] esel;
      @(negedge clk);
      check("frame_start", 32'(frame_start), 32'(rstn && (k % F == 0)));
      @(posedge clk);
      if (!rstn) begin
         es = 8'hFF; esel = 4'hF; k = 0;
         m_data = '0; m_dot = '0; m_blank = '0; m_blink = '0; m_lz = 1'b0; m_ph = 1'b0;
      end else begin
         expect_out(k, es, esel);
         if (k % F == 0) begin
            m_data = data_in; m_dot = dot_en; m_blank = blank_en; m_blink = blink_en;
            m_lz = lz_suppress; m_ph = ((k / B) % 2) == 1;
         end
         k++;
      end
      #1;
      check("seg", 32'(seg), 32'(es));
      check("sel", 32'(sel), 32'(esel));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rstn = 1'b0; data_in = 16'h1234; dot_en = '0; blank_en = '0; blink_en = '0;
      lz_suppress = 1'b0;
      run(3);
      rstn = 1'b1;
      run(2 * F);
      data_in = 16'hABCF; dot_en = 4'b0100;
      run(2 * F + 3);
      data_in = 16'h0005; lz_suppress = 1'b1; dot_en = 4'b0010;
      run(2 * F);
      data_in = 16'h0000;
      run(F + 5);
      // Mid-frame change must not tear the displayed frame
      data_in = 16'h1111; dot_en = '0; lz_suppress = 1'b0;
      for (int i = 0; i < 2 * F && (k % F) != 12; i++) tick();
      data_in = 16'h2222;
      run(2 * F);
      blink_en = 4'b0001; blank_en = 4'b1000; data_in = 16'h5678;
      run(300);
      // Single-cycle reset while digit 2 is being scanned
      for (int i = 0; i < 2 * F && !(((k / S) % N) == 2 && (k % S) == 4); i++) tick();
      rstn = 1'b0;
      run(1);
      rstn = 1'b1;
      run(2 * F);
      repeat (40) begin
         for (int i = 0; i < 4; i++)
            data_in[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         dot_en = 4'($urandom); blank_en = 4'($urandom); blink_en = 4'($urandom);
         lz_suppress = 1'($urandom);
         run($urandom_range(5, 120));
         if ($urandom_range(0, 7) == 0) begin
            rstn = 1'b0;
            run($urandom_range(1, 3));
            rstn = 1'b1;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
